// File: rtl/even_operand_fetch.sv
// Even-pipe operand fetch: 128x128 register file, forwarding from the even-pipe stages and RAW hazard stall.
// Latency: one cycle from an accepted instruction to the registered operand outputs. Backpressure: in_ready drops
// combinationally while a source register waits on an in-flight result. Ports: decoded instruction in, forwarding packets in, operands out.
module even_operand_fetch (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:10]  in_opcode,
  input  logic [0:17]  in_immediate,
  input  logic [0:6]   in_addr_ra,
  input  logic [0:6]   in_addr_rb,
  input  logic [0:6]   in_addr_rc,
  input  logic [0:6]   in_addr_rt,
  input  logic [0:2]   in_latency,
  input  logic [0:138] fwe2_in,
  input  logic [0:138] fwe3_in,
  input  logic [0:138] fwe4_in,
  input  logic [0:138] fwe5_in,
  input  logic [0:138] fwe6_in,
  input  logic [0:138] fwe7_in,
  input  logic [0:138] rf_wbe_in,
  output logic [0:127] data_ra,
  output logic [0:127] data_rb,
  output logic [0:127] data_rc,
  output logic [0:10]  opcode,
  output logic [0:17]  immediate,
  output logic [0:6]   addr_rt
);

  localparam logic [0:10] NOP = 11'b01000000001;

  // Packet layout: [0:127] data, [128:130] unit tag, [131] write-valid, [132:138] target.
  logic [0:138] fwd [0:6];
  assign fwd[0] = fwe2_in;
  assign fwd[1] = fwe3_in;
  assign fwd[2] = fwe4_in;
  assign fwd[3] = fwe5_in;
  assign fwd[4] = fwe6_in;
  assign fwd[5] = fwe7_in;
  assign fwd[6] = rf_wbe_in;

  logic [0:127] rf [0:127];

  // In-flight tracker: a ring written every cycle. An entry lives for ages 1..7,
  // so the slot the pointer returns to after 8 cycles is always already retired.
  logic [7:0] trk_vld;
  logic [6:0] trk_rt  [8];
  logic [2:0] trk_lat [8];
  logic [3:0] trk_age [8];
  logic [2:0] wr_ptr;

  logic [0:127] op_ra, op_rb, op_rc;
  logic         hazard;
  logic         issue;
  logic [2:0]   lat_eff;

  // Scan from lowest priority (register file, then rf_wbe) up to fwe2 so the
  // highest-priority match is the last assignment and wins.
  always_comb begin
    op_ra = rf[in_addr_ra];
    op_rb = rf[in_addr_rb];
    op_rc = rf[in_addr_rc];
    for (int k = 6; k >= 0; k--) begin
      if (fwd[k][131] && fwd[k][132:138] == in_addr_ra) op_ra = fwd[k][0:127];
      if (fwd[k][131] && fwd[k][132:138] == in_addr_rb) op_rb = fwd[k][0:127];
      if (fwd[k][131] && fwd[k][132:138] == in_addr_rc) op_rc = fwd[k][0:127];
    end
  end

  // An entry is pending while its age is still below the result stage.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (trk_vld[i] && ({1'b0, trk_lat[i]} > trk_age[i]) &&
          (trk_rt[i] == in_addr_ra || trk_rt[i] == in_addr_rb || trk_rt[i] == in_addr_rc))
        hazard = 1'b1;
    end
  end

  assign in_ready = !(in_valid && hazard);
  assign issue    = in_valid && !hazard && !flush;
  assign lat_eff  = (in_latency < 3'd2) ? 3'd2 : in_latency;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 128; r++) rf[r] <= '0;
    end else if (rf_wbe_in[131]) begin
      rf[rf_wbe_in[132:138]] <= rf_wbe_in[0:127];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trk_vld <= '0;
      wr_ptr  <= '0;
      for (int i = 0; i < 8; i++) begin
        trk_rt[i]  <= '0;
        trk_lat[i] <= '0;
        trk_age[i] <= '0;
      end
    end else begin
      wr_ptr <= wr_ptr + 3'd1;
      for (int i = 0; i < 8; i++) begin
        if (trk_vld[i]) begin
          if (trk_age[i] == 4'd7) trk_vld[i] <= 1'b0;
          else                    trk_age[i] <= trk_age[i] + 4'd1;
          // Flush kills only instructions whose result is not yet available.
          if (flush && ({1'b0, trk_lat[i]} > trk_age[i])) trk_vld[i] <= 1'b0;
        end
      end
      if (issue) begin
        trk_vld[wr_ptr] <= 1'b1;
        trk_rt[wr_ptr]  <= in_addr_rt;
        trk_lat[wr_ptr] <= lat_eff;
        trk_age[wr_ptr] <= 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_ra   <= '0;
      data_rb   <= '0;
      data_rc   <= '0;
      opcode    <= NOP;
      immediate <= '0;
      addr_rt   <= '0;
    end else if (issue) begin
      data_ra   <= op_ra;
      data_rb   <= op_rb;
      data_rc   <= op_rc;
      opcode    <= in_opcode;
      immediate <= in_immediate;
      addr_rt   <= in_addr_rt;
    end else begin
      data_ra   <= '0;
      data_rb   <= '0;
      data_rc   <= '0;
      opcode    <= NOP;
      immediate <= '0;
      addr_rt   <= '0;
    end
  end

endmodule

// File: tb/tb_even_operand_fetch.sv
// Testbench for even_operand_fetch: random and directed stimulus against a reference model
// built from issue history (issue cycle, target, latency) and a plain register array.
// Ports: none; drives every DUT port and prints one summary line.
module tb_even_operand_fetch;

  localparam logic [0:10] NOP = 11'b01000000001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, flush, in_valid, in_ready;
  logic [0:10]  in_opcode;
  logic [0:17]  in_immediate;
  logic [0:6]   in_addr_ra, in_addr_rb, in_addr_rc, in_addr_rt;
  logic [0:2]   in_latency;
  logic [0:138] pk [7];
  logic [0:127] data_ra, data_rb, data_rc;
  logic [0:10]  opcode;
  logic [0:17]  immediate;
  logic [0:6]   addr_rt;

  even_operand_fetch dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_immediate(in_immediate),
    .in_addr_ra(in_addr_ra), .in_addr_rb(in_addr_rb), .in_addr_rc(in_addr_rc),
    .in_addr_rt(in_addr_rt), .in_latency(in_latency),
    .fwe2_in(pk[0]), .fwe3_in(pk[1]), .fwe4_in(pk[2]), .fwe5_in(pk[3]),
    .fwe6_in(pk[4]), .fwe7_in(pk[5]), .rf_wbe_in(pk[6]),
    .data_ra(data_ra), .data_rb(data_rb), .data_rc(data_rc),
    .opcode(opcode), .immediate(immediate), .addr_rt(addr_rt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: issued instructions remembered with the cycle they issued.
  typedef struct {int cyc; int rt; int lat; bit live;} inflight_t;
  inflight_t    hist[$];
  logic [0:127] mrf [128];
  int           cyc;
  logic [0:127] e_ra, e_rb, e_rc;
  logic [0:10]  e_op;
  logic [0:17]  e_imm;
  logic [0:6]   e_rt;
  bit           m_ready, m_issue, last_ready;

  function automatic bit m_pending(int a);
    foreach (hist[i])
      if (hist[i].live && hist[i].rt == a && (cyc - hist[i].cyc + 1) < hist[i].lat) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [0:127] m_read(int a);
    for (int k = 0; k < 7; k++)
      if (pk[k][131] && int'(pk[k][132:138]) == a) return pk[k][0:127];
    return mrf[a];
  endfunction

  function automatic logic [0:138] mkpkt(input logic [0:127] d, input logic v, input logic [0:6] a);
    return {d, 3'b000, v, a};
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 128; r++) mrf[r] = '0;
    hist.delete();
    cyc = 0;
  endtask

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0;
    in_opcode = 11'h123; in_immediate = '0;
    in_addr_ra = '0; in_addr_rb = '0; in_addr_rc = '0; in_addr_rt = '0; in_latency = 3'd2;
    for (int k = 0; k < 7; k++) pk[k] = '0;
  endtask

  task automatic rand_inputs();
    in_valid     = ($urandom_range(3) != 0);
    flush        = ($urandom_range(15) == 0);
    in_opcode    = 11'($urandom);
    in_immediate = 18'($urandom);
    in_addr_ra   = 7'($urandom_range(7));
    in_addr_rb   = 7'($urandom_range(7));
    in_addr_rc   = 7'($urandom_range(7));
    in_addr_rt   = 7'($urandom_range(7));
    in_latency   = 3'($urandom_range(7));
    for (int k = 0; k < 7; k++)
      pk[k] = mkpkt({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(1)), 7'($urandom_range(7)));
  endtask

  // One clock: check in_ready mid-cycle, predict the registered outputs,
  // advance the model at the edge, then check the outputs just after it.
  task automatic cycle();
    int lat;
    @(negedge clk);
    m_ready = !(in_valid && (m_pending(int'(in_addr_ra)) || m_pending(int'(in_addr_rb)) ||
                             m_pending(int'(in_addr_rc))));
    last_ready = in_ready;
    chk("in_ready", in_ready, m_ready);
    m_issue = in_valid && m_ready && !flush;
    if (m_issue) begin
      e_ra = m_read(int'(in_addr_ra)); e_rb = m_read(int'(in_addr_rb)); e_rc = m_read(int'(in_addr_rc));
      e_op = in_opcode; e_imm = in_immediate; e_rt = in_addr_rt;
    end else begin
      e_ra = '0; e_rb = '0; e_rc = '0; e_op = NOP; e_imm = '0; e_rt = '0;
    end
    lat = (int'(in_latency) < 2) ? 2 : int'(in_latency);
    @(posedge clk);
    if (pk[6][131]) mrf[int'(pk[6][132:138])] = pk[6][0:127];
    if (flush)
      foreach (hist[i]) if ((cyc - hist[i].cyc + 1) < hist[i].lat) hist[i].live = 1'b0;
    cyc++;
    if (m_issue) hist.push_back('{cyc, int'(in_addr_rt), lat, 1'b1});
    while (hist.size() > 0 && (cyc - hist[0].cyc + 1) >= 8) void'(hist.pop_front());
    #1;
    chk("data_ra", data_ra, e_ra);
    chk("data_rb", data_rb, e_rb);
    chk("data_rc", data_rc, e_rc);
    chk("opcode", opcode, e_op);
    chk("immediate", immediate, e_imm);
    chk("addr_rt", addr_rt, e_rt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int stalls;
    bit issued;
    reset = 1'b1;
    idle();
    model_reset();
    in_valid = 1'b1;
    #2;
    chk("reset_opcode", opcode, NOP);
    chk("reset_data_ra", data_ra, '0);
    chk("reset_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 reset = 1'b0;
    idle();

    // Writeback of r5 then a read of r5 through the register file.
    pk[6] = mkpkt({16{8'hAA}}, 1'b1, 7'd5);
    cycle();
    idle();
    in_valid = 1'b1; in_addr_ra = 7'd5; in_addr_rt = 7'd1;
    cycle();
    chk("r5_readback", data_ra, {16{8'hAA}});

    // fwe3 and fwe6 both target r9: fwe3 must win for both ports.
    idle();
    pk[1] = mkpkt({32{4'h3}}, 1'b1, 7'd9);
    pk[4] = mkpkt({32{4'h6}}, 1'b1, 7'd9);
    in_valid = 1'b1; in_addr_ra = 7'd9; in_addr_rb = 7'd9; in_addr_rt = 7'd2;
    cycle();
    chk("fwd_prio_ra", data_ra, {32{4'h3}});
    chk("fwd_prio_rb", data_rb, {32{4'h3}});

    // RAW on a latency-6 producer: five stall cycles, then forward from fwe6.
    idle();
    repeat (8) cycle();
    in_valid = 1'b1; in_addr_rt = 7'd10; in_latency = 3'd6;
    cycle();
    in_addr_ra = 7'd10; in_addr_rt = 7'd3;
    pk[4] = mkpkt({32{4'hD}}, 1'b1, 7'd10);
    stalls = 0; issued = 1'b0;
    for (int n = 0; n < 12 && !issued; n++) begin
      cycle();
      if (!last_ready) stalls++;
      else issued = 1'b1;
    end
    chk("raw_stall_cycles", 128'(stalls), 128'd5);
    chk("raw_fwd_fwe6", data_ra, {32{4'hD}});

    // Flush while a dependent instruction is stalled on a latency-7 producer.
    idle();
    repeat (8) cycle();
    in_valid = 1'b1; in_addr_rt = 7'd12; in_latency = 3'd7;
    cycle();
    in_addr_ra = 7'd12; in_addr_rt = 7'd4;
    repeat (2) cycle();
    chk("flush_pre_stall", last_ready, 1'b0);
    flush = 1'b1;
    cycle();
    chk("flush_bubble", opcode, NOP);
    flush = 1'b0;
    cycle();
    chk("flush_ready_after", last_ready, 1'b1);

    // Random traffic with latency, flush and forwarding mixes.
    for (int n = 0; n < 600; n++) begin
      rand_inputs();
      cycle();
    end

    // Asynchronous reset in the middle of a cycle.
    rand_inputs();
    flush = 1'b0; in_valid = 1'b1;
    cycle();
    #2 reset = 1'b1;
    #1;
    chk("async_rst_opcode", opcode, NOP);
    chk("async_rst_data", data_ra, '0);
    chk("async_rst_rt", addr_rt, '0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    idle();
    in_valid = 1'b1; in_addr_ra = 7'd5; in_addr_rt = 7'd1;
    cycle();
    chk("r5_after_reset", data_ra, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/even_operand_fetch.md
EVEN_OPERAND_FETCH -- requirements
Module: even_operand_fetch

Interface
REQ-001 SHALL have ports: clk in 1 (clock); reset in 1 (asynchronous, active-high, single clock domain); flush in 1 (pipeline flush).
REQ-002 SHALL have ports: in_valid in 1 (decoded instruction present); in_ready out 1 (stage accepts instruction this cycle).
REQ-003 SHALL have ports: in_opcode in [0:10]; in_immediate in [0:17]; in_addr_ra, in_addr_rb, in_addr_rc, in_addr_rt in [0:6] each; in_latency in [0:2] (even-pipe result stage, legal 2..7).
REQ-004 SHALL have ports: fwe2_in through fwe7_in, rf_wbe_in, each in [0:138] (forwarding and writeback packets from the even pipe).
REQ-005 SHALL have ports: data_ra, data_rb, data_rc out [0:127]; opcode out [0:10]; immediate out [0:17]; addr_rt out [0:6]; all registered, feeding the even pipe.
REQ-006 SHALL interpret every packet as: [0:127] result data, [128:130] unit tag (ignored), [131] write-valid, [132:138] target register.

Function
REQ-007 SHALL contain a 128 x 128-bit register file, written at posedge clk from rf_wbe_in[0:127] to entry rf_wbe_in[132:138] when rf_wbe_in[131]=1.
REQ-008 SHALL resolve each source operand combinationally, first match wins: fwe2_in, fwe3_in, fwe4_in, fwe5_in, fwe6_in, fwe7_in, rf_wbe_in, then register file. A match is packet[131]=1 and packet[132:138] equal to the source address.
REQ-009 SHALL resolve ra, rb and rc independently, including when two or all three addresses are equal.
REQ-010 SHALL keep an in-flight tracker of up to 8 entries {valid, rt, latency, age}; an entry is created with age=1 when an instruction issues; age increments every cycle; the entry retires when age reaches 8.
REQ-011 SHALL treat an in-flight entry as pending while age < latency.
REQ-012 SHALL deassert in_ready combinationally when in_valid=1 and any of in_addr_ra, in_addr_rb or in_addr_rc equals rt of a pending entry; otherwise in_ready=1.
REQ-013 SHALL issue when in_valid=1, in_ready=1 and flush=0: on the next posedge, load the outputs with the resolved operands, in_opcode, in_immediate and in_addr_rt, and create a tracker entry.
REQ-014 SHALL load a bubble when no issue occurs: opcode=11'b01000000001 (nop), data outputs zero, immediate zero, addr_rt zero; no tracker entry created.
REQ-015 SHALL give one-cycle latency from accepted input to registered output; sustained throughput is one instruction per cycle without hazards.
REQ-016 SHALL, on flush=1 at a posedge, load a bubble, ignore in_valid, and invalidate all tracker entries that are still pending; register file writes continue unaffected.
REQ-017 SHALL not stall on in_addr_rt conflicts (write-after-write ordering is guaranteed by the forwarding priority).
REQ-018 SHALL, for illegal in_latency (0, 1), treat the instruction as latency 2.

Reset
REQ-019 SHALL, while reset=1 (asynchronously), hold outputs at bubble values (opcode nop, data/immediate/addr_rt zero), clear all tracker entries, and clear all register file entries to zero.
REQ-020 SHALL drive in_ready=1 during reset and accept no instruction until the first posedge after reset deasserts.
REQ-021 SHALL abort any in-flight state when reset asserts mid-operation; no partial writes survive.

Verification
REQ-022 Write r5=0xAA..AA via rf_wbe_in, then issue ra=5 -> data_ra=0xAA..AA one cycle after issue.
REQ-023 fwe3_in and fwe6_in both carry valid packets for r9 (0x3.., 0x6..), with ra=rb=9 -> data_ra=data_rb=0x3.. (fwe3 priority).
REQ-024 Issue rt=10 with latency 6, then immediately present ra=10 -> in_ready=0 for 5 cycles; issue occurs when age reaches 6, with data taken from fwe6_in.
REQ-025 Assert flush while a latency-7 rt=12 entry is pending and a dependent ra=12 instruction is stalled -> bubble output next cycle, in_ready=1 the cycle after flush.
REQ-026 Assert reset asynchronously mid-stream -> outputs immediately show nop/zero; after release, reading r5 returns zero.
